digit_entry: RTL

Keypad entry register for the digital alarm clock. It collects debounced digit keystrokes into a 16-bit BCD HH:MM word (`set_data`) that feeds the display driver's set-mode path. It validates the entry and, on a Time or Alarm button press, issues a one-cycle load strobe to the time counter or the alarm register. It is the writer of the `set_data` word that the display side reads and shows.

---
 rtl/digit_entry.sv | 125 ++++++++++++
 1 files changed

// File: rtl/digit_entry.sv
// Keypad entry register: gathers BCD digits into an HH:MM word, validates it,
// and issues one-cycle load strobes to the time counter or alarm register.
module digit_entry #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_second,
    input  logic [3:0]  key,
    input  logic        key_strobe,
    input  logic        alarm_button,
    input  logic        time_button,
    output logic [15:0] set_data,
    output logic [2:0]  digit_count,
    output logic        load_new_alarm,
    output logic        load_new_time,
    output logic        entry_error
);

    typedef enum logic [1:0] {IDLE, ENTRY, FULL} state_t;

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt, tmo_nxt;
    logic        alarm_prev, time_prev;
    logic [15:0] data_nxt;
    logic [2:0]  count_nxt;
    logic        la_nxt, lt_nxt, err_nxt;

    logic alarm_edge, time_edge, btn_edge, key_ok, time_valid, commit_ok, tick_final;

    assign alarm_edge = alarm_button & ~alarm_prev;
    assign time_edge  = time_button & ~time_prev;
    assign btn_edge   = alarm_edge | time_edge;
    assign key_ok     = key_strobe && (key <= 4'd9);

    // Digits are always 0-9, so HH<=23 and MM<=59 reduce to nibble compares.
    assign time_valid = ((set_data[15:12] < 4'd2) ||
                         (set_data[15:12] == 4'd2 && set_data[11:8] <= 4'd3)) &&
                        (set_data[7:4] <= 4'd5);
    assign commit_ok  = (state == FULL) && (alarm_edge ^ time_edge) && time_valid;
    assign tick_final = one_second && (state != IDLE) &&
                        ((tmo_cnt + 8'd1) == 8'(TIMEOUT_SEC));

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            set_data       <= 16'h0000;
            digit_count    <= 3'd0;
            tmo_cnt        <= 8'd0;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_error    <= 1'b0;
            alarm_prev     <= 1'b1;
            time_prev      <= 1'b1;
        end else begin
            state          <= state_nxt;
            set_data       <= data_nxt;
            digit_count    <= count_nxt;
            tmo_cnt        <= tmo_nxt;
            load_new_alarm <= la_nxt;
            load_new_time  <= lt_nxt;
            entry_error    <= err_nxt;
            alarm_prev     <= alarm_button;
            time_prev      <= time_button;
        end
    end

    // Priority: button edge, then accepted key, then timeout.
    always_comb begin
        state_nxt = state;
        if (btn_edge) begin
            state_nxt = IDLE;
        end else if (key_ok) begin
            case (state)
                IDLE:    state_nxt = ENTRY;
                ENTRY:   state_nxt = (digit_count == 3'd3) ? FULL : ENTRY;
                default: state_nxt = FULL;
            endcase
        end else if (tick_final) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        data_nxt  = set_data;
        count_nxt = digit_count;
        tmo_nxt   = tmo_cnt;
        la_nxt    = 1'b0;
        lt_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (btn_edge) begin
            count_nxt = 3'd0;
            tmo_nxt   = 8'd0;
            if (commit_ok) begin
                la_nxt = alarm_edge;
                lt_nxt = time_edge;
            end else begin
                err_nxt  = 1'b1;
                data_nxt = 16'h0000;
            end
        end else if (key_ok) begin
            tmo_nxt = 8'd0;
            if (state == FULL) begin
                err_nxt = 1'b1;
            end else if (state == IDLE) begin
                data_nxt  = {12'h000, key};
                count_nxt = 3'd1;
            end else begin
                data_nxt  = {set_data[11:0], key};
                count_nxt = digit_count + 3'd1;
            end
        end else if (state == IDLE) begin
            tmo_nxt = 8'd0;
        end else if (one_second) begin
            if (tick_final) begin
                data_nxt  = 16'h0000;
                count_nxt = 3'd0;
                tmo_nxt   = 8'd0;
            end else begin
                tmo_nxt = tmo_cnt + 8'd1;
            end
        end
    end

endmodule
